// File: rtl/ws2_pkg.sv
// Shared constants for the MAX3421E SPI initiator: register numbers, command
// byte layout and the transfer FSM state type.
package ws2_pkg;

  localparam logic [4:0] REG_USBIRQ   = 5'd13;
  localparam logic [4:0] REG_USBCTL   = 5'd15;
  localparam logic [4:0] REG_PINCTL   = 5'd17;
  localparam logic [4:0] REG_REVISION = 5'd18;
  localparam logic [4:0] REG_HIRQ     = 5'd25;

  // Command byte is {reg[4:0], 1'b0, dir, ackstat}
  localparam int DIR_BIT     = 1;
  localparam int ACKSTAT_BIT = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } spi_state_t;

  function automatic logic [7:0] make_cmd(input logic [4:0] addr,
                                          input logic       wr,
                                          input logic       ack);
    logic [7:0] c;
    c              = {addr, 3'b000};
    c[DIR_BIT]     = wr;
    c[ACKSTAT_BIT] = ack;
    return c;
  endfunction

endpackage

// File: rtl/max3421e_spi_master_clk_div.sv
// Half-period tick generator: tick fires on the last Clk cycle of every
// CLK_DIV-cycle window while enabled; restart realigns the window.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic restart,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (Reset || restart) cnt <= RELOAD;
    else if (en)          cnt <= (cnt == '0) ? RELOAD : cnt - CW'(1);
  end

  assign tick = en && (cnt == '0);

endmodule

// File: rtl/max3421e_spi_master.sv
// SPI mode-0 initiator running one 16-bit MAX3421E register access per start:
// command byte then data byte, MSB first, with CS setup/hold/gap framing.
module max3421e_spi_master
  import ws2_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       start,
  input  logic [4:0] reg_addr,
  input  logic       write,
  input  logic       ackstat,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic [7:0] status,
  output logic       spi_cs_n,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  spi_state_t  state, state_nxt;
  logic        tick, accept;
  logic [7:0]  cmd_byte;
  logic [15:0] sr;       // tx bits shift out of the top, rx bits shift in at the bottom
  logic [4:0]  bit_cnt;  // number of rising edges issued so far

  assign accept   = (state == S_IDLE) && start;
  assign cmd_byte = make_cmd(reg_addr, write, ackstat);

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .Clk     (Clk),
    .Reset   (Reset),
    .restart (accept),
    .en      (state != S_IDLE),
    .tick    (tick)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SETUP;
      S_SETUP: if (tick)  state_nxt = S_SHIFT;
      S_SHIFT: if (tick && spi_sclk && bit_cnt == 5'd16) state_nxt = S_HOLD;
      S_HOLD:  if (tick)  state_nxt = S_GAP;
      S_GAP:   if (tick)  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      rdata    <= 8'h00;
      status   <= 8'h00;
      spi_cs_n <= 1'b1;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      sr       <= 16'h0000;
      bit_cnt  <= 5'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          sr       <= {cmd_byte, write ? wdata : 8'h00};
          busy     <= 1'b1;
          spi_cs_n <= 1'b0;
          spi_sclk <= 1'b0;
          spi_mosi <= cmd_byte[7];
          bit_cnt  <= 5'd0;
        end
        S_SETUP: if (tick) begin
          spi_sclk <= 1'b1;
          bit_cnt  <= 5'd1;
        end
        S_SHIFT: if (tick) begin
          if (spi_sclk) begin
            // End of high phase: sample MISO, then present the next MOSI bit
            spi_sclk <= 1'b0;
            sr       <= {sr[14:0], spi_miso};
            if (bit_cnt != 5'd16) spi_mosi <= sr[14];
          end else begin
            spi_sclk <= 1'b1;
            bit_cnt  <= bit_cnt + 5'd1;
          end
        end
        S_HOLD: if (tick) begin
          spi_cs_n <= 1'b1;
          spi_mosi <= 1'b0;
          done     <= 1'b1;
          status   <= sr[15:8];
          rdata    <= sr[7:0];
        end
        S_GAP: if (tick) busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_max3421e_spi_master.sv
// Directed bench for max3421e_spi_master with a cycle-level MAX3421E responder
// model on each of two instances (CLK_DIV=4 and CLK_DIV=2).
module tb_max3421e_spi_master;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       start, write, ackstat;
  logic [4:0] reg_addr;
  logic [7:0] wdata;
  logic       busy, done, spi_cs_n, spi_sclk, spi_mosi, spi_miso;
  logic [7:0] rdata, status;

  logic       start2, write2, ackstat2;
  logic [4:0] reg_addr2;
  logic [7:0] wdata2;
  logic       busy2, done2, cs2_n, sclk2, mosi2, miso2;
  logic [7:0] rdata2, status2;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int c0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  max3421e_spi_master #(.CLK_DIV(4)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .reg_addr(reg_addr), .write(write),
    .ackstat(ackstat), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .status(status), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
  );

  max3421e_spi_master #(.CLK_DIV(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .start(start2), .reg_addr(reg_addr2), .write(write2),
    .ackstat(ackstat2), .wdata(wdata2), .busy(busy2), .done(done2), .rdata(rdata2),
    .status(status2), .spi_cs_n(cs2_n), .spi_sclk(sclk2), .spi_mosi(mosi2),
    .spi_miso(miso2)
  );

  // Responder model + monitor for dut; pins only move on posedge, so sample on negedge
  logic [7:0]  m_status = 8'h01, m_data = 8'h13;
  logic [15:0] m_tx = '0, m_rx = '0;
  int          m_bits = 0;
  logic [7:0]  m_wreg = '0;
  logic [4:0]  m_waddr = '0;
  logic        p_cs = 1'b1, p_sclk = 1'b0, p_busy = 1'b0;
  int          done_cnt = 0, done_abs = 0, cs_fall_abs = 0, busy_fall_abs = 0;
  int          hi_run = 0, hi_run_fall = 0;

  assign spi_miso = m_tx[15];

  always @(negedge Clk) begin
    if (p_cs === 1'b1 && spi_cs_n === 1'b0) begin
      m_tx        <= {m_status, m_data};
      m_bits      <= 0;
      cs_fall_abs <= cyc;
      hi_run_fall <= hi_run;
    end
    if (spi_cs_n === 1'b0 && p_sclk === 1'b0 && spi_sclk === 1'b1) begin
      m_rx   <= {m_rx[14:0], spi_mosi};
      m_bits <= m_bits + 1;
    end
    if (spi_cs_n === 1'b0 && p_sclk === 1'b1 && spi_sclk === 1'b0) m_tx <= {m_tx[14:0], 1'b0};
    if (p_cs === 1'b0 && spi_cs_n === 1'b1 && m_bits == 16 && m_rx[9]) begin
      m_waddr <= m_rx[15:11];
      m_wreg  <= m_rx[7:0];
    end
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_abs <= cyc;
    end
    if (p_busy === 1'b1 && busy === 1'b0) busy_fall_abs <= cyc;
    hi_run <= (spi_cs_n === 1'b1) ? hi_run + 1 : 0;
    p_cs   <= spi_cs_n;
    p_sclk <= spi_sclk;
    p_busy <= busy;
  end

  // Responder model + monitor for dut2
  logic [7:0]  m2_status = 8'h00, m2_data = 8'hA5;
  logic [15:0] m2_tx = '0, m2_rx = '0;
  logic        p2_cs = 1'b1, p2_sclk = 1'b0;
  int          done2_abs = 0, rise_n = 0, rise1_abs = 0, rise2_abs = 0;

  assign miso2 = m2_tx[15];

  always @(negedge Clk) begin
    if (p2_cs === 1'b1 && cs2_n === 1'b0) begin
      m2_tx  <= {m2_status, m2_data};
      rise_n <= 0;
    end
    if (cs2_n === 1'b0 && p2_sclk === 1'b0 && sclk2 === 1'b1) begin
      m2_rx  <= {m2_rx[14:0], mosi2};
      rise_n <= rise_n + 1;
      if (rise_n == 0) rise1_abs <= cyc;
      if (rise_n == 1) rise2_abs <= cyc;
    end
    if (cs2_n === 1'b0 && p2_sclk === 1'b1 && sclk2 === 1'b0) m2_tx <= {m2_tx[14:0], 1'b0};
    if (done2 === 1'b1) done2_abs <= cyc;
    p2_cs   <= cs2_n;
    p2_sclk <= sclk2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  int base;

  initial begin
    Reset = 1'b1; start = 1'b0; write = 1'b0; ackstat = 1'b0; reg_addr = '0; wdata = '0;
    start2 = 1'b0; write2 = 1'b0; ackstat2 = 1'b0; reg_addr2 = '0; wdata2 = '0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_cs_n",   spi_cs_n, 1);
    chk("rst_sclk",   spi_sclk, 0);
    chk("rst_mosi",   spi_mosi, 0);
    chk("rst_busy",   busy,     0);
    chk("rst_done",   done,     0);
    chk("rst_rdata",  rdata,    0);
    chk("rst_status", status,   0);
    Reset = 1'b0;
    repeat (2) @(posedge Clk);

    // Reset mid-transfer at cycle 60
    base = done_cnt;
    @(posedge Clk); #1; c0 = cyc;
    start = 1'b1; reg_addr = 5'd18; write = 1'b0; ackstat = 1'b0; wdata = 8'h00;
    @(posedge Clk); #1; start = 1'b0;
    repeat (59) @(posedge Clk);
    #1; Reset = 1'b1;
    @(posedge Clk); #1;
    chk("abort_cs_n", spi_cs_n, 1);
    chk("abort_sclk", spi_sclk, 0);
    chk("abort_busy", busy,     0);
    Reset = 1'b0;
    repeat (200) @(posedge Clk); #1;
    chk("abort_no_done", done_cnt - base, 0);
    chk("abort_rdata",   rdata,  0);
    chk("abort_status",  status, 0);

    // Read rREVISION
    base = done_cnt;
    @(posedge Clk); #1; c0 = cyc;
    start = 1'b1; reg_addr = 5'd18; write = 1'b0; ackstat = 1'b0; wdata = 8'h55;
    @(posedge Clk); #1; start = 1'b0;
    chk("rd_busy_c1", busy,     1);
    chk("rd_cs_c1",   spi_cs_n, 0);
    chk("rd_mosi_c1", spi_mosi, 1);
    repeat (145) @(posedge Clk); #1;
    chk("rd_mosi_stream", m_rx,   16'h9000);
    chk("rd_rdata",       rdata,  8'h13);
    chk("rd_status",      status, 8'h01);
    chk("rd_done_cnt",    done_cnt - base, 1);
    chk("rd_done_cyc",    done_abs - c0, 133);
    chk("rd_busy_fall",   busy_fall_abs - c0, 137);

    // Write rPINCTL
    @(posedge Clk); #1; c0 = cyc;
    start = 1'b1; reg_addr = 5'd17; write = 1'b1; ackstat = 1'b0; wdata = 8'h10;
    @(posedge Clk); #1; start = 1'b0;
    repeat (145) @(posedge Clk); #1;
    chk("wr_mosi_stream", m_rx,    16'h8A10);
    chk("wr_model_data",  m_wreg,  8'h10);
    chk("wr_model_addr",  m_waddr, 5'd17);
    chk("wr_busy_fall",   busy_fall_abs - c0, 137);

    // Inputs change at cycle 10; latched values must be used
    @(posedge Clk); #1; c0 = cyc;
    start = 1'b1; reg_addr = 5'd15; write = 1'b1; ackstat = 1'b1; wdata = 8'h3C;
    @(posedge Clk); #1; start = 1'b0;
    repeat (9) @(posedge Clk); #1;
    reg_addr = 5'd5; wdata = 8'hFF; write = 1'b0; ackstat = 1'b0;
    repeat (140) @(posedge Clk); #1;
    chk("latch_mosi_stream", m_rx,    16'h7B3C);
    chk("latch_model_data",  m_wreg,  8'h3C);
    chk("latch_model_addr",  m_waddr, 5'd15);

    // start held high for 200 cycles
    m_data = 8'h5A;
    base = done_cnt;
    @(posedge Clk); #1; c0 = cyc;
    start = 1'b1; reg_addr = 5'd18; write = 1'b0; ackstat = 1'b0; wdata = 8'h00;
    repeat (200) @(posedge Clk); #1; start = 1'b0;
    repeat (150) @(posedge Clk); #1;
    chk("hold_txn_cnt",   done_cnt - base, 2);
    chk("hold_cs_fall2",  cs_fall_abs - c0, 138);
    chk("hold_cs_gap_ge4", (hi_run_fall >= 4), 1);
    chk("hold_rdata",     rdata, 8'h5A);

    // CLK_DIV=2 instance, read rHIRQ
    @(posedge Clk); #1; c0 = cyc;
    start2 = 1'b1; reg_addr2 = 5'd25; write2 = 1'b0; ackstat2 = 1'b0; wdata2 = 8'h00;
    @(posedge Clk); #1; start2 = 1'b0;
    repeat (80) @(posedge Clk); #1;
    chk("d2_mosi_stream", m2_rx,  16'hC800);
    chk("d2_rdata",       rdata2, 8'hA5);
    chk("d2_status",      status2, 8'h00);
    chk("d2_done_cyc",    done2_abs - c0, 67);
    chk("d2_rise1_cyc",   rise1_abs - c0, 3);
    chk("d2_sclk_period", rise2_abs - rise1_abs, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
